controle_rodadas: RTL and testbench

CONTROLE_RODADAS -- requirements
Module: controle_rodadas

---
 rtl/controle_rodadas_pkg.sv | 27 ++
 rtl/contador_timeout.sv | 36 +++
 rtl/controle_rodadas.sv | 145 ++++++++++++++
 tb/tb_controle_rodadas.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_rodadas_pkg.sv
// Shared definitions for the round controller: state codes, last-round limits and
// the default play timeout.
package controle_rodadas_pkg;

  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPrepara      = 4'h1,
    StIniciaRodada = 4'h2,
    StEspera       = 4'h3,
    StRegistra     = 4'h4,
    StCompara      = 4'h5,
    StProxEnd      = 4'h6,
    StProxRodada   = 4'h7,
    StFimAcerto    = 4'hA,
    StFimTimeout   = 4'hD,
    StFimErro      = 4'hE
  } estado_t;

  localparam logic [3:0]  UltimaRodadaCurto   = 4'd7;
  localparam logic [3:0]  UltimaRodadaLongo   = 4'd15;
  localparam int unsigned TimeoutCiclosPadrao = 5000;

  function automatic logic [3:0] ultima_rodada(input logic nivel);
    return nivel ? UltimaRodadaLongo : UltimaRodadaCurto;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Saturating per-play timeout counter; terminal asserts once Ciclos-1 cycles have elapsed.
module contador_timeout #(
  parameter int unsigned Ciclos = 5000
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int unsigned Largura = (Ciclos > 1) ? $clog2(Ciclos) : 1;
  localparam logic [Largura-1:0] Fim = Largura'(Ciclos - 1);

  logic [Largura-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != Fim)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == Fim);

endmodule

// File: rtl/controle_rodadas.sv
// Moore control unit for the memory game: sequences rounds and plays, drives the
// datapath strobes and reports win, mistake or timeout.
module controle_rodadas
  import controle_rodadas_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = TimeoutCiclosPadrao
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       sel_nivel,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_end,
  input  logic [3:0] limite,
  output logic       zera_end,
  output logic       conta_end,
  output logic       zera_lim,
  output logic       conta_lim,
  output logic       zera_reg,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  logic    nivel_q, nivel_d;
  logic    jogada_q;
  logic    borda;
  logic    tmo_clear, tmo_enable, tmo_fim;

  // Only a fresh press counts; a key still held from the previous play is ignored.
  assign borda   = jogada & ~jogada_q;
  assign nivel_d = (estado_q == StPrepara) ? sel_nivel : nivel_q;

  contador_timeout #(
    .Ciclos(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock_i   (clock),
    .reset_ni  (reset),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .terminal_o(tmo_fim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= StInicial;
      nivel_q  <= 1'b0;
      jogada_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      nivel_q  <= nivel_d;
      jogada_q <= jogada;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    zera_end   = 1'b0;
    conta_end  = 1'b0;
    zera_lim   = 1'b0;
    conta_lim  = 1'b0;
    zera_reg   = 1'b0;
    registra   = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    db_timeout = 1'b0;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;
    case (estado_q)
      StInicial: begin
        if (iniciar) estado_d = StPrepara;
      end
      StPrepara: begin
        zera_end = 1'b1;
        zera_lim = 1'b1;
        zera_reg = 1'b1;
        estado_d = StIniciaRodada;
      end
      StIniciaRodada: begin
        zera_end  = 1'b1;
        tmo_clear = 1'b1;
        estado_d  = StEspera;
      end
      StEspera: begin
        tmo_enable = 1'b1;
        // A press in the expiry cycle still counts as a play.
        if (borda) begin
          estado_d = StRegistra;
        end else if (tmo_fim) begin
          estado_d = StFimTimeout;
        end
      end
      StRegistra: begin
        registra = 1'b1;
        estado_d = StCompara;
      end
      StCompara: begin
        if (!igual) begin
          estado_d = StFimErro;
        end else if (!fim_end) begin
          estado_d = StProxEnd;
        end else if (limite == ultima_rodada(nivel_q)) begin
          estado_d = StFimAcerto;
        end else begin
          estado_d = StProxRodada;
        end
      end
      StProxEnd: begin
        conta_end = 1'b1;
        tmo_clear = 1'b1;
        estado_d  = StEspera;
      end
      StProxRodada: begin
        conta_lim = 1'b1;
        estado_d  = StIniciaRodada;
      end
      StFimAcerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) estado_d = StPrepara;
      end
      StFimErro: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) estado_d = StPrepara;
      end
      StFimTimeout: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
        if (iniciar) estado_d = StPrepara;
      end
      default: estado_d = StInicial;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// Directed bench for controle_rodadas with a behavioural datapath and a game-result scoreboard.
module tb_controle_rodadas;
  import controle_rodadas_pkg::*;

  localparam int unsigned Tmo = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       sel_nivel = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b1;
  logic       fim_end;
  logic [3:0] limite;
  logic       zera_end, conta_end, zera_lim, conta_lim, zera_reg, registra;
  logic       pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;
  logic [9:0] saidas;

  controle_rodadas #(
    .TIMEOUT_CICLOS(Tmo)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .sel_nivel (sel_nivel),
    .jogada    (jogada),
    .igual     (igual),
    .fim_end   (fim_end),
    .limite    (limite),
    .zera_end  (zera_end),
    .conta_end (conta_end),
    .zera_lim  (zera_lim),
    .conta_lim (conta_lim),
    .zera_reg  (zera_reg),
    .registra  (registra),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .db_timeout(db_timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  assign saidas = {zera_end, conta_end, zera_lim, conta_lim, zera_reg, registra,
                   pronto, acertou, errou, db_timeout};

  // Datapath model: address and limit counters driven by the controller strobes.
  logic [3:0] end_q = 4'd0;
  logic [3:0] lim_q = 4'd0;
  always @(posedge clock) begin
    if (!reset) begin
      end_q <= 4'd0;
      lim_q <= 4'd0;
    end else begin
      if (zera_end) end_q <= 4'd0;
      else if (conta_end) end_q <= end_q + 4'd1;
      if (zera_lim) lim_q <= 4'd0;
      else if (conta_lim) lim_q <= lim_q + 4'd1;
    end
  end
  assign fim_end = (end_q == lim_q);
  assign limite  = lim_q;

  int lim_pulses = 0;
  always @(negedge clock) if (conta_lim === 1'b1) lim_pulses++;

  typedef struct {
    estado_t estado;
    int      n_lim;
    logic    acertou;
    logic    errou;
    logic    tmo;
  } esperado_t;

  esperado_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int lim_base = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_estado(input estado_t code);
    for (int i = 0; i < 100; i++) begin
      if (db_estado == code) break;
      tick();
    end
    check("wait_estado", 32'(db_estado), 32'(code));
  endtask

  task automatic press(input int len);
    jogada = 1'b1;
    repeat (len) tick();
    jogada = 1'b0;
    repeat (2) tick();
  endtask

  task automatic play_round(input int r, input int len, input int err_play);
    for (int p = 0; p <= r; p++) begin
      wait_estado(StEspera);
      igual = (p != err_play);
      press(len);
      igual = 1'b1;
      if (p == err_play) return;
    end
  endtask

  task automatic play_rounds(input int first, input int last, input int len,
                             input int err_round, input int err_play, input bit toggle);
    for (int r = first; r <= last; r++) begin
      if (toggle && r == 4) sel_nivel = ~sel_nivel;
      play_round(r, len, (r == err_round) ? err_play : -1);
      if (r == err_round) break;
    end
  endtask

  task automatic expect_game(input estado_t est, input int n, input logic ac,
                             input logic er, input logic tm);
    esperado_t e;
    e.estado  = est;
    e.n_lim   = n;
    e.acertou = ac;
    e.errou   = er;
    e.tmo     = tm;
    sb.push_back(e);
  endtask

  task automatic start_game(input logic lvl);
    sel_nivel = lvl;
    iniciar   = 1'b1;
    tick();
    iniciar   = 1'b0;
    lim_base  = lim_pulses;
    check("prepara_estado", 32'(db_estado), 32'(StPrepara));
    check("prepara_zera_end", 32'(zera_end), 32'd1);
    check("prepara_zera_lim", 32'(zera_lim), 32'd1);
  endtask

  task automatic finish_game();
    esperado_t e;
    for (int i = 0; i < 200; i++) begin
      if (pronto === 1'b1) break;
      tick();
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("fim_estado", 32'(db_estado), 32'(e.estado));
    check("fim_pronto", 32'(pronto), 32'd1);
    check("fim_acertou", 32'(acertou), 32'(e.acertou));
    check("fim_errou", 32'(errou), 32'(e.errou));
    check("fim_timeout", 32'(db_timeout), 32'(e.tmo));
    check("conta_lim_pulses", 32'(lim_pulses - lim_base), 32'(e.n_lim));
  endtask

  initial begin
    // Reset for 10 cycles, then release with iniciar low.
    repeat (10) tick();
    check("reset_estado", 32'(db_estado), 32'(StInicial));
    check("reset_saidas", 32'(saidas), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_estado", 32'(db_estado), 32'(StInicial));
    check("idle_saidas", 32'(saidas), 32'd0);

    // Eight-round game, all plays correct.
    expect_game(StFimAcerto, 7, 1'b1, 1'b0, 1'b0);
    start_game(1'b0);
    tick();
    check("inicia_estado", 32'(db_estado), 32'(StIniciaRodada));
    check("inicia_zera_end", 32'(zera_end), 32'd1);
    check("inicia_zera_lim", 32'(zera_lim), 32'd0);
    play_rounds(0, 7, 1, -1, -1, 1'b0);
    finish_game();

    // Sixteen-round game, 5-cycle key pulses, sel_nivel flipped mid-game.
    expect_game(StFimAcerto, 15, 1'b1, 1'b0, 1'b0);
    start_game(1'b1);
    play_rounds(0, 15, 5, -1, -1, 1'b1);
    finish_game();

    // Wrong second play in round 3; the end state must hold without iniciar.
    expect_game(StFimErro, 2, 1'b0, 1'b1, 1'b0);
    start_game(1'b0);
    play_rounds(0, 7, 1, 2, 1, 1'b0);
    finish_game();
    repeat (3) tick();
    check("erro_hold", 32'(db_estado), 32'(StFimErro));

    // Restart from FIM_ERRO, then let the first play time out.
    expect_game(StFimTimeout, 0, 1'b0, 1'b1, 1'b1);
    start_game(1'b0);
    wait_estado(StEspera);
    repeat (Tmo - 1) tick();
    check("espera_antes_timeout", 32'(db_estado), 32'(StEspera));
    tick();
    check("timeout_no_ciclo_20", 32'(db_estado), 32'(StFimTimeout));
    finish_game();

    // Key edge in the expiry cycle wins, then reset in COMPARA of round 5.
    start_game(1'b0);
    wait_estado(StEspera);
    repeat (Tmo - 1) tick();
    jogada = 1'b1;
    tick();
    check("borda_vence_timeout", 32'(db_estado), 32'(StRegistra));
    check("registra_alto", 32'(registra), 32'd1);
    jogada = 1'b0;
    tick();
    check("compara_estado", 32'(db_estado), 32'(StCompara));
    check("registra_um_ciclo", 32'(registra), 32'd0);
    play_rounds(1, 3, 1, -1, -1, 1'b0);
    wait_estado(StEspera);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    check("rodada5_compara", 32'(db_estado), 32'(StCompara));
    reset = 1'b0;
    tick();
    check("reset_meio_estado", 32'(db_estado), 32'(StInicial));
    check("reset_meio_saidas", 32'(saidas), 32'd0);
    reset = 1'b1;
    tick();
    check("pos_reset_estado", 32'(db_estado), 32'(StInicial));
    start_game(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
